avg_unpool_unit: RTL and testbench

- Inverse-direction companion to the CNN core's average-pooling stage.
- Takes a stream of pooled values and expands each one back into a POOL-element window, one element per handshake.
- Mode 0 replicates the value (nearest-neighbour upsample for decoder layers). Mode 1 distributes it as value/POOL (average-pool gradient for the backward path).
- Sits between the pooled-feature buffer and the next layer's MAC array. Uses valid/ready on both sides, with a 2-entry input buffer so the upstream can run ahead by one value.

---
 rtl/avg_unpool_unit.sv | 121 ++++++++++++
 tb/tb_avg_unpool_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_unpool_unit.sv
// avg_unpool_unit
//   Expands each pooled value into a POOL-element window, one element per
//   output handshake. Mode 0 replicates the value (nearest-neighbour
//   upsample); mode 1 emits value >>> POOL_LOG2 (average-pool gradient).
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   clear              synchronous flush of buffer, pointers and window counter
//   in_valid/in_ready  input handshake; in_data/in_mode captured on accept
//   out_valid/out_ready output handshake
//   out_data           expanded element (0 when out_valid is low)
//   out_idx            element position within its window
//   out_last           high with the final element of a window
module avg_unpool_unit #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned POOL      = 4,
  parameter int unsigned POOL_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [POOL_LOG2-1:0] out_idx,
  output logic                 out_last
);

  if ((POOL != (32'd1 << POOL_LOG2)) || (POOL < 2) || (POOL > 16)) begin : g_bad_cfg
    $fatal(1, "avg_unpool_unit: POOL must be a power of two in 2..16 equal to 2**POOL_LOG2");
  end

  localparam logic [POOL_LOG2-1:0] LastIdx = POOL_LOG2'(POOL - 1);
  localparam logic [POOL_LOG2-1:0] IdxOne  = POOL_LOG2'(1);

  // Entry layout: {mode, data}
  logic [DATA_W:0]      mem_q [2];
  logic [DATA_W:0]      mem_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic [POOL_LOG2-1:0] cnt_q, cnt_d;

  logic                     push;
  logic                     out_fire;
  logic                     pop;
  logic [DATA_W:0]          head;
  logic signed [DATA_W-1:0] head_data;
  logic signed [DATA_W-1:0] head_shifted;

  // Outputs depend only on state (and rst for in_ready), never on out_ready.
  always_comb begin
    in_ready     = (count_q < 2'd2) && !rst;
    out_valid    = (count_q != 2'd0);
    head         = mem_q[rd_ptr_q];
    head_data    = head[DATA_W-1:0];
    head_shifted = head_data >>> POOL_LOG2;
    out_data     = '0;
    if (out_valid) begin
      out_data = head[DATA_W] ? head_shifted : head_data;
    end
    out_idx  = cnt_q;
    out_last = out_valid && (cnt_q == LastIdx);
  end

  always_comb begin
    push     = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    pop      = out_fire && out_last;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cnt_d    = cnt_q;

    if (clear) begin
      // Abandon everything, including any handshake in this cycle.
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {in_mode, in_data};
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (out_fire) begin
        cnt_d = pop ? '0 : (cnt_q + IdxOne);
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset: it is only observed through out_valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_avg_unpool_unit.sv
module tb_avg_unpool_unit;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data;
  logic               in_mode;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic [1:0]         out_idx;
  logic               out_last;

  int n_cmp = 0;
  int n_err = 0;

  avg_unpool_unit #(
    .DATA_W   (32),
    .POOL     (4),
    .POOL_LOG2(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  // Advance one edge; sample point is 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready);
    end
    n_cmp++;
    if ({out_valid, out_last} !== 2'b00 || out_data !== 0 || out_idx !== 2'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%0b d=%0d i=%0d l=%0b expected 0 0 0 0",
               out_valid, out_data, out_idx, out_last);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_in_ready: got %0b expected 1", in_ready);
    end
  endtask

  task automatic test_replicate();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 7; in_mode = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 7 || out_idx !== 2'(i) || out_last !== (i == 3)) begin
        n_err++;
        $display("FAIL replicate_elem%0d: got v=%0b d=%0d i=%0d l=%0b expected 1 7 %0d %0b",
                 i, out_valid, out_data, out_idx, out_last, i, (i == 3));
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 0) begin
      n_err++; $display("FAIL replicate_drained: got v=%0b d=%0d expected 0 0", out_valid, out_data);
    end
  endtask

  task automatic test_distribute();
    int vals [3] = '{20, -5, -4};
    int exp_v [3] = '{5, -2, -1};
    int p = 0;
    int k = 0;
    bit started = 0;
    bit saw_full = 0;
    bit gap = 0;
    out_ready = 1'b1;
    in_mode = 1'b1;
    for (int c = 0; c < 30 && k < 12; c++) begin
      if (in_ready && p < 3) begin
        in_valid = 1'b1; in_data = vals[p]; p++;
      end else begin
        in_valid = 1'b0;
      end
      if (started && in_ready === 1'b0) saw_full = 1;
      if (out_valid) begin
        started = 1;
        n_cmp++;
        if (out_data !== exp_v[k / 4] || out_idx !== 2'(k % 4) || out_last !== ((k % 4) == 3)) begin
          n_err++;
          $display("FAIL distribute_elem%0d: got d=%0d i=%0d l=%0b expected %0d %0d %0b",
                   k, out_data, out_idx, out_last, exp_v[k / 4], k % 4, ((k % 4) == 3));
        end
        k++;
      end else if (started) begin
        gap = 1;
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (k !== 12 || gap !== 1'b0) begin
      n_err++; $display("FAIL distribute_contiguous: got count=%0d gap=%0b expected 12 0", k, gap);
    end
    n_cmp++;
    if (saw_full !== 1'b1) begin
      n_err++; $display("FAIL distribute_full_stall: got saw_ready_low=%0b expected 1", saw_full);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL distribute_drained: got v=%0b expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    int emitted = 0;
    bit fired;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 3; in_mode = 1'b0;
    tick();
    in_data = 8;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_second_accept: got in_ready=%0b expected 1", in_ready);
    end
    tick();
    in_data = 11;
    for (int s = 0; s < 4; s++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 3 || out_idx !== 2'd0 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_stall%0d: got v=%0b d=%0d i=%0d rdy=%0b expected 1 3 0 0",
                 s, out_valid, out_data, out_idx, in_ready);
      end
      tick();
    end
    for (int c = 0; c < 20 && emitted < 4; c++) begin
      out_ready = (c % 2 == 0);
      n_cmp++;
      if (out_data !== 3 || out_idx !== 2'(emitted) || in_ready !== 1'b0 ||
          out_last !== (emitted == 3)) begin
        n_err++;
        $display("FAIL bp_toggle%0d: got d=%0d i=%0d rdy=%0b l=%0b expected 3 %0d 0 %0b",
                 c, out_data, out_idx, in_ready, out_last, emitted, (emitted == 3));
      end
      fired = out_ready;
      tick();
      if (fired) emitted++;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (out_data !== 8 || out_idx !== 2'd0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_next_window: got d=%0d i=%0d rdy=%0b expected 8 0 1",
               out_data, out_idx, in_ready);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int j = 1; j < 8; j++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== ((j < 4) ? 8 : 11) || out_idx !== 2'(j % 4)) begin
        n_err++;
        $display("FAIL bp_drain%0d: got v=%0b d=%0d i=%0d expected 1 %0d %0d",
                 j, out_valid, out_data, out_idx, (j < 4) ? 8 : 11, j % 4);
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_drained: got v=%0b expected 0", out_valid);
    end
  endtask

  task automatic test_mixed();
    int exp_v [2] = '{4, 16};
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16; in_mode = 1'b1;
    tick();
    in_mode = 1'b0;
    n_cmp++;
    if (out_data !== 4 || out_idx !== 2'd0) begin
      n_err++; $display("FAIL mixed_elem0: got d=%0d i=%0d expected 4 0", out_data, out_idx);
    end
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      in_mode = ~in_mode;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp_v[k / 4] || out_idx !== 2'(k % 4)) begin
        n_err++;
        $display("FAIL mixed_elem%0d: got v=%0b d=%0d i=%0d expected 1 %0d %0d",
                 k, out_valid, out_data, out_idx, exp_v[k / 4], k % 4);
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL mixed_drained: got v=%0b expected 0", out_valid);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 9; in_mode = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (out_data !== 9 || out_idx !== 2'd2) begin
      n_err++; $display("FAIL midrst_before: got d=%0d i=%0d expected 9 2", out_data, out_idx);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL midrst_in_ready: got %0b expected 0", in_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_idx !== 2'd0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_after: got v=%0b i=%0d rdy=%0b expected 0 0 1",
               out_valid, out_idx, in_ready);
    end
    in_valid = 1'b1; in_data = 1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 1 || out_idx !== 2'(i)) begin
        n_err++;
        $display("FAIL midrst_new%0d: got v=%0b d=%0d i=%0d expected 1 1 %0d",
                 i, out_valid, out_data, out_idx, i);
      end
      tick();
    end
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 5; in_mode = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_data !== 5 || out_idx !== 2'd1) begin
      n_err++; $display("FAIL clear_before: got d=%0d i=%0d expected 5 1", out_data, out_idx);
    end
    clear = 1'b1; in_valid = 1'b1; in_data = 6;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 0 || out_idx !== 2'd0) begin
      n_err++;
      $display("FAIL clear_after: got v=%0b rdy=%0b d=%0d i=%0d expected 0 1 0 0",
               out_valid, in_ready, out_data, out_idx);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL clear_not_stored: got v=%0b expected 0", out_valid);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 2;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 2 || out_idx !== 2'd0) begin
      n_err++;
      $display("FAIL clear_restart: got v=%0b d=%0d i=%0d expected 1 2 0",
               out_valid, out_data, out_idx);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 0; in_mode = 1'b0; out_ready = 1'b0;
    test_reset();
    test_replicate();
    test_distribute();
    test_backpressure();
    test_mixed();
    test_mid_reset();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $fatal(1);
  end

endmodule
